// File: rtl/ring_osc_trim_cal.sv
// ring_osc_trim_cal: closed-loop trim calibration for a ring oscillator.
// Resets the oscillator, lets it settle, counts divided-clock edges over a
// window, and walks a thermometer trim code until the count is in tolerance.
// Optional continuous tracking after lock: define RING_OSC_CAL_TRACK_EN.
module ring_osc_trim_cal #(
    parameter int RST_CYC    = 16,
    parameter int SETTLE_CYC = 64,
    parameter int MAX_ITER   = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        osc_div,
    input  logic [4:0]  init_code,
    input  logic [15:0] window,
    input  logic [15:0] target,
    input  logic [7:0]  tol,
    output logic [25:0] trim,
    output logic [4:0]  trim_code,
    output logic        osc_reset,
    output logic        busy,
    output logic        locked,
    output logic        fail,
    output logic [15:0] meas_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_OSCRST, S_SETTLE, S_MEASURE, S_ADJUST, S_LOCK, S_FAIL
    } state_t;

    state_t      state;
    logic [15:0] cnt;
    logic [15:0] edge_cnt;
    logic [7:0]  iter;
    logic [15:0] win_r, tgt_r;
    logic [7:0]  tol_r;
    logic        s1, s2, s3;

    // Code n lights the n low bits of the trim bus (both 13-bit halves fill in order).
    function automatic logic [25:0] therm(input logic [4:0] code);
        logic [25:0] t;
        for (int i = 0; i < 26; i++) t[i] = (i < int'(code));
        return t;
    endfunction

    // osc_div is asynchronous: two flops to resolve metastability, third for edge detect.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= osc_div;
            s2 <= s1;
            s3 <= s2;
        end
    end

    logic        osc_edge;
    logic [15:0] next_edge;
    logic [16:0] hi_lim;
    logic [15:0] lo_lim;
    logic        too_fast, too_slow, iter_hit, can_start;

    assign osc_edge  = s2 & ~s3;
    assign next_edge = (osc_edge && edge_cnt != 16'hFFFF) ? edge_cnt + 16'd1 : edge_cnt;
    // Upper limit kept 17 bits wide so target+tol cannot wrap; lower floored at 0.
    assign hi_lim    = {1'b0, tgt_r} + {9'd0, tol_r};
    assign lo_lim    = (tgt_r > {8'd0, tol_r}) ? tgt_r - {8'd0, tol_r} : 16'd0;
    assign too_fast  = {1'b0, meas_count} > hi_lim;
    assign too_slow  = meas_count < lo_lim;
    assign can_start = start && (state == S_IDLE || state == S_LOCK || state == S_FAIL);
`ifdef RING_OSC_CAL_TRACK_EN
    // Once locked we are tracking drift, where the iteration budget no longer applies.
    assign iter_hit  = (iter == 8'(MAX_ITER)) && !locked;
`else
    assign iter_hit  = (iter == 8'(MAX_ITER));
`endif

    // Calibration sequencer: all outputs are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            trim_code  <= 5'd0;
            trim       <= 26'd0;
            osc_reset  <= 1'b1;
            busy       <= 1'b0;
            locked     <= 1'b0;
            fail       <= 1'b0;
            meas_count <= 16'd0;
            cnt        <= 16'd0;
            edge_cnt   <= 16'd0;
            iter       <= 8'd0;
            win_r      <= 16'd0;
            tgt_r      <= 16'd0;
            tol_r      <= 8'd0;
        end else if (can_start) begin
            state     <= S_OSCRST;
            trim_code <= (init_code > 5'd26) ? 5'd26 : init_code;
            iter      <= 8'd0;
            locked    <= 1'b0;
            fail      <= 1'b0;
            busy      <= 1'b1;
            osc_reset <= 1'b1;
            cnt       <= 16'd0;
            win_r     <= window;
            tgt_r     <= target;
            tol_r     <= tol;
        end else begin
            case (state)
                S_OSCRST: begin
                    if (cnt == 16'(RST_CYC - 1)) begin
                        osc_reset <= 1'b0;
                        trim      <= therm(trim_code);
                        cnt       <= 16'd0;
                        state     <= S_SETTLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_SETTLE: begin
                    if (win_r == 16'd0) begin
                        fail   <= 1'b1;
                        locked <= 1'b0;
                        busy   <= 1'b0;
                        state  <= S_FAIL;
                    end else if (cnt == 16'(SETTLE_CYC - 1)) begin
                        cnt      <= 16'd0;
                        edge_cnt <= 16'd0;
                        state    <= S_MEASURE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_MEASURE: begin
                    edge_cnt <= next_edge;
                    if (cnt == win_r - 16'd1) begin
                        meas_count <= next_edge;
                        state      <= S_ADJUST;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_ADJUST: begin
                    if (too_fast || too_slow) begin
                        if (iter_hit || (too_fast && trim_code == 5'd26) ||
                            (too_slow && trim_code == 5'd0)) begin
                            fail   <= 1'b1;
                            locked <= 1'b0;
                            busy   <= 1'b0;
                            state  <= S_FAIL;
                        end else begin
                            trim_code <= too_fast ? trim_code + 5'd1 : trim_code - 5'd1;
                            trim      <= therm(too_fast ? trim_code + 5'd1 : trim_code - 5'd1);
                            iter      <= iter + 8'd1;
                            cnt       <= 16'd0;
                            state     <= S_SETTLE;
                        end
                    end else begin
                        locked <= 1'b1;
                        busy   <= 1'b0;
                        state  <= S_LOCK;
                    end
                end
`ifdef RING_OSC_CAL_TRACK_EN
                S_LOCK: begin
                    trim  <= therm(trim_code);
                    cnt   <= 16'd0;
                    busy  <= 1'b1;
                    state <= S_SETTLE;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ring_osc_trim_cal.sv
// Testbench for ring_osc_trim_cal: a rate-programmable oscillator model plus a
// behavioural reference of the calibration search.
module tb_ring_osc_trim_cal;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        osc_div = 1'b0;
    logic [4:0]  init_code = 5'd0;
    logic [15:0] window = 16'd0;
    logic [15:0] target = 16'd0;
    logic [7:0]  tol = 8'd0;
    logic [25:0] trim;
    logic [4:0]  trim_code;
    logic        osc_reset, busy, locked, fail;
    logic [15:0] meas_count;

    int tests = 0;
    int fails = 0;

    // Oscillator model knobs: mode 0 = base - slope*code, mode 1 = alternating hi/lo.
    int r_mode = 0, r_base = 0, r_slope = 0, r_hi = 0, r_lo = 0;
    int acc = 0;

    ring_osc_trim_cal dut (
        .clk(clk), .reset(reset), .start(start), .osc_div(osc_div),
        .init_code(init_code), .window(window), .target(target), .tol(tol),
        .trim(trim), .trim_code(trim_code), .osc_reset(osc_reset),
        .busy(busy), .locked(locked), .fail(fail), .meas_count(meas_count)
    );

    always #5 clk = ~clk;

    // Edges per window as a function of trim code, capped so pulses stay separated.
    function automatic int rate_of(input int code);
        int n;
        if (r_mode == 1) n = (code % 2 == 0) ? r_hi : r_lo;
        else             n = r_base - r_slope * code;
        if (n < 0) n = 0;
        if (n > int'(window) / 2) n = int'(window) / 2;
        return n;
    endfunction

    // Phase accumulator: exactly N one-cycle pulses in any `window` consecutive cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (window == 16'd0) begin
                osc_div = 1'b0;
                acc = 0;
            end else begin
                acc = acc % int'(window) + rate_of($countones(trim));
                if (acc >= int'(window)) begin
                    acc = acc - int'(window);
                    osc_div = 1'b1;
                end else begin
                    osc_div = 1'b0;
                end
            end
        end
    end

    // Reference search: measure at the current code, step toward target, stop on lock/limit.
    function automatic void model(input int init, input int w, input int t, input int tl,
                                  output int code, output bit lk, output bit fl,
                                  output int meas, output int adj);
        int m, lo;
        code = (init > 26) ? 26 : init;
        lk = 0; fl = 0; meas = -1; adj = 0;
        if (w == 0) begin
            fl = 1;
            return;
        end
        lo = (t > tl) ? t - tl : 0;
        for (int k = 0; k < 1000; k++) begin
            m = rate_of(code);
            meas = m;
            if (m > t + tl) begin
                if (adj == 32 || code == 26) begin fl = 1; return; end
                code++; adj++;
            end else if (m < lo) begin
                if (adj == 32 || code == 0) begin fl = 1; return; end
                code--; adj++;
            end else begin
                lk = 1;
                return;
            end
        end
    endfunction

    // Start a calibration and follow it until busy drops; optionally re-pulse start at cycle `poke`.
    task automatic run_cal(input int init, input int w, input int t, input int tl, input int poke,
                           output bit to, output int rst_hi, output int adj);
        int prev;
        init_code = 5'(init);
        window = 16'(w);
        target = 16'(t);
        tol = 8'(tl);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst_hi = 0; adj = 0; to = 1; prev = int'(trim_code);
        for (int c = 0; c < 60000; c++) begin
            if (c == poke) begin
                init_code = 5'd20;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (osc_reset) rst_hi++;
            if (int'(trim_code) != prev) adj++;
            prev = int'(trim_code);
            if (!busy) begin
                to = 0;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({trim, trim_code, osc_reset, busy, locked, fail, meas_count} !==
            {26'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0}) begin
            fails++;
            $display("FAIL reset_state: trim=%h code=%0d osc_reset=%b busy=%b locked=%b fail=%b meas=%0d, want 0/0/1/0/0/0/0",
                     trim, trim_code, osc_reset, busy, locked, fail, meas_count);
        end
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if (osc_reset !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_hold: osc_reset=%b busy=%b, want 1/0", osc_reset, busy);
        end
    endtask

    task automatic test_lock_basic();
        bit to; int rst_hi, adj;
        r_mode = 0; r_base = 200; r_slope = 0;
        run_cal(0, 1000, 200, 5, -1, to, rst_hi, adj);
        tests++;
        if (to) begin fails++; $display("FAIL basic_timeout: busy still high"); end
        tests++;
        if (rst_hi !== 16) begin fails++; $display("FAIL basic_osc_reset_len: got %0d want 16", rst_hi); end
        tests++;
        if ({locked, fail, busy, trim_code, trim, meas_count} !== {1'b1, 1'b0, 1'b0, 5'd0, 26'd0, 16'd200}) begin
            fails++;
            $display("FAIL basic_lock: locked=%b fail=%b busy=%b code=%0d trim=%h meas=%0d want 1/0/0/0/0/200",
                     locked, fail, busy, trim_code, trim, meas_count);
        end
    endtask

    task automatic test_stepping();
        bit to, lk, fl; int rst_hi, adj, ec, em, ea;
        logic [25:0] want_trim;
        r_mode = 0; r_base = 360; r_slope = 10;
        model(10, 1000, 200, 4, ec, lk, fl, em, ea);
        run_cal(10, 1000, 200, 4, -1, to, rst_hi, adj);
        want_trim = 26'h0001FFF | (26'h7 << 13);
        tests++;
        if (to) begin fails++; $display("FAIL step_timeout: busy still high"); end
        tests++;
        if (int'(trim_code) != ec || locked !== lk || fail !== fl || adj != ea) begin
            fails++;
            $display("FAIL step_result: code=%0d locked=%b fail=%b adj=%0d want %0d/%b/%b/%0d",
                     trim_code, locked, fail, adj, ec, lk, fl, ea);
        end
        tests++;
        if (trim !== want_trim || trim_code !== 5'd16 || int'(meas_count) != em) begin
            fails++;
            $display("FAIL step_trim: trim=%h code=%0d meas=%0d want %h/16/%0d", trim, trim_code, meas_count, want_trim, em);
        end
    endtask

    task automatic test_boundary_fail();
        bit to; int rst_hi, adj;
        r_mode = 0; r_base = 400; r_slope = 0;
        run_cal(26, 1000, 200, 5, -1, to, rst_hi, adj);
        tests++;
        if (to) begin fails++; $display("FAIL bound_timeout: busy still high"); end
        tests++;
        if ({fail, locked, busy, trim, meas_count} !== {1'b1, 1'b0, 1'b0, 26'h3FFFFFF, 16'd400} || adj != 0) begin
            fails++;
            $display("FAIL bound_fail: fail=%b locked=%b busy=%b trim=%h meas=%0d adj=%0d want 1/0/0/3ffffff/400/0",
                     fail, locked, busy, trim, meas_count, adj);
        end
    endtask

    task automatic test_max_iter();
        bit to, lk, fl; int rst_hi, adj, ec, em, ea;
        logic [25:0] want_trim;
        r_mode = 1; r_hi = 60; r_lo = 20;
        model(10, 200, 40, 2, ec, lk, fl, em, ea);
        run_cal(10, 200, 40, 2, -1, to, rst_hi, adj);
        want_trim = (26'd1 << ec) - 26'd1;
        tests++;
        if (to) begin fails++; $display("FAIL iter_timeout: busy still high"); end
        tests++;
        if (fail !== 1'b1 || locked !== 1'b0 || adj != 32 || ea != 32) begin
            fails++;
            $display("FAIL iter_limit: fail=%b locked=%b adj=%0d want 1/0/32", fail, locked, adj);
        end
        tests++;
        if (int'(trim_code) != ec || trim !== want_trim || int'(meas_count) != em) begin
            fails++;
            $display("FAIL iter_final: code=%0d trim=%h meas=%0d want %0d/%h/%0d", trim_code, trim, meas_count, ec, want_trim, em);
        end
    endtask

    task automatic test_reset_mid();
        r_mode = 0; r_base = 200; r_slope = 0;
        init_code = 5'd7; window = 16'd1000; target = 16'd200; tol = 8'd5;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (200) @(negedge clk);
        tests++;
        if (busy !== 1'b1 || osc_reset !== 1'b0 || trim_code !== 5'd7) begin
            fails++;
            $display("FAIL mid_measuring: busy=%b osc_reset=%b code=%0d want 1/0/7", busy, osc_reset, trim_code);
        end
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if ({trim, trim_code, osc_reset, busy, locked, fail, meas_count} !==
            {26'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0}) begin
            fails++;
            $display("FAIL mid_reset: trim=%h code=%0d osc_reset=%b busy=%b locked=%b fail=%b meas=%0d want reset values",
                     trim, trim_code, osc_reset, busy, locked, fail, meas_count);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit to; int rst_hi, adj;
        r_mode = 0; r_base = 40; r_slope = 0;
        run_cal(5, 200, 40, 2, 5, to, rst_hi, adj);
        tests++;
        if (to || rst_hi != 16 || trim_code !== 5'd5 || locked !== 1'b1 || meas_count !== 16'd40) begin
            fails++;
            $display("FAIL busy_start: to=%b rst_hi=%0d code=%0d locked=%b meas=%0d want 0/16/5/1/40",
                     to, rst_hi, trim_code, locked, meas_count);
        end
        run_cal(3, 0, 40, 2, -1, to, rst_hi, adj);
        tests++;
        if (to || fail !== 1'b1 || locked !== 1'b0 || meas_count !== 16'd40 || rst_hi != 16 || trim_code !== 5'd3) begin
            fails++;
            $display("FAIL window_zero: to=%b fail=%b locked=%b meas=%0d rst_hi=%0d code=%0d want 0/1/0/40/16/3",
                     to, fail, locked, meas_count, rst_hi, trim_code);
        end
    endtask

    task automatic test_random();
        bit to, lk, fl; int rst_hi, adj, ec, em, ea, w, t, tl, init;
        for (int k = 0; k < 6; k++) begin
            w = $urandom_range(200, 100);
            t = $urandom_range(w / 2 - 10, 20);
            tl = $urandom_range(8, 0);
            init = $urandom_range(31, 0);
            r_mode = 0;
            r_slope = $urandom_range(12, 1);
            r_base = t + r_slope * $urandom_range(26, 0) + $urandom_range(40, 0) - 20;
            window = 16'(w);
            model(init, w, t, tl, ec, lk, fl, em, ea);
            run_cal(init, w, t, tl, -1, to, rst_hi, adj);
            tests++;
            if (to || int'(trim_code) != ec || locked !== lk || fail !== fl ||
                int'(meas_count) != em || adj != ea || trim !== (26'd1 << ec) - 26'd1) begin
                fails++;
                $display("FAIL random_%0d: to=%b code=%0d locked=%b fail=%b meas=%0d adj=%0d want %0d/%b/%b/%0d/%0d",
                         k, to, trim_code, locked, fail, meas_count, adj, ec, lk, fl, em, ea);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock_basic();
        test_stepping();
        test_boundary_fail();
        test_max_iter();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
